// File: rtl/lutram_fifo_pkg.sv
// Shared constants and helpers for the LUTRAM-backed request FIFO.
package lutram_fifo_pkg;

  // Byte granularity of LUTRAM write enables.
  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  // Number of byte lanes in an entry of the given width.
  function automatic int unsigned entry_num_bytes(input int unsigned width_in_bits);
    return width_in_bits / BYTE_LEN_IN_BITS;
  endfunction

endpackage

// File: rtl/dual_port_lutram.sv
// Simple dual-port distributed RAM: one byte-masked write port and one
// registered read port. The array itself is never reset.
module dual_port_lutram
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_SET                    = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter string       CONFIG_MODE                = "ReadFirst",
  parameter string       WITH_VALID_REG_ARRAY       = "Yes"
) (
  input  logic                                                 reset_in,
  input  logic                                                 clk_in,

  input  logic                                                 read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                     read_set_addr_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                read_entry_out,

  input  logic                                                 access_en_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS/BYTE_LEN_IN_BITS-1:0] write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                     write_set_addr_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                write_entry_in
);

  localparam int unsigned NUM_BYTES   = entry_num_bytes(SINGLE_ENTRY_WIDTH_IN_BITS);
  localparam bit          WRITE_FIRST = (CONFIG_MODE == "WriteFirst");
  localparam bit          VALID_ARRAY = (WITH_VALID_REG_ARRAY == "Yes");

  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem [NUM_SET];
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_merged;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_next;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_q;
  logic [NUM_SET-1:0]                    valid_q;

  // Merge the enabled byte lanes of the incoming word over the stored word.
  always_comb begin
    write_merged = mem[write_set_addr_in];
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (write_en_in[b]) begin
        write_merged[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
          write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
      end
    end
  end

  // Storage array write; deliberately unreset so it maps onto LUT RAM.
  always_ff @(posedge clk_in) begin
    if (access_en_in) begin
      mem[write_set_addr_in] <= write_merged;
    end
  end

  if (VALID_ARRAY) begin : g_valid_array
    // Per-set written flag, cleared on reset, so never-written sets read as zero.
    always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
        valid_q <= '0;
      end else if (access_en_in) begin
        valid_q[write_set_addr_in] <= 1'b1;
      end
    end
  end else begin : g_no_valid_array
    assign valid_q = '1;
  end

  // Select read data: old contents (ReadFirst) or same-cycle write forwarding (WriteFirst).
  always_comb begin
    read_next = mem[read_set_addr_in];
    if (WRITE_FIRST && access_en_in && (write_set_addr_in == read_set_addr_in)) begin
      read_next = write_merged;
    end
    if (VALID_ARRAY && !valid_q[read_set_addr_in]) begin
      read_next = '0;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      read_entry_q <= '0;
    end else if (read_en_in) begin
      read_entry_q <= read_next;
    end
  end

  assign read_entry_out = read_entry_q;

endmodule

// File: rtl/lutram_fifo.sv
// Synchronous request FIFO using dual_port_lutram as storage. The consumer
// sees a registered valid/data pair; one push and one pop per cycle.
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_ENTRY                  = 16,
  parameter int unsigned PTR_WIDTH_IN_BITS          = $clog2(NUM_ENTRY),
  parameter int unsigned COUNT_WIDTH_IN_BITS        = $clog2(NUM_ENTRY) + 1
) (
  input  logic                                  reset_in,
  input  logic                                  clk_in,

  input  logic                                  request_valid_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  output logic                                  issue_ack_out,

  output logic                                  request_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  input  logic                                  issue_ack_in,

  output logic                                  fifo_full_out,
  output logic                                  fifo_empty_out,
  output logic [COUNT_WIDTH_IN_BITS-1:0]        count_out
);

  localparam int unsigned NUM_BYTES = entry_num_bytes(SINGLE_ENTRY_WIDTH_IN_BITS);

  logic [PTR_WIDTH_IN_BITS-1:0]          head_q;
  logic [PTR_WIDTH_IN_BITS-1:0]          tail_q;
  logic [PTR_WIDTH_IN_BITS-1:0]          read_addr;
  logic [COUNT_WIDTH_IN_BITS-1:0]        count_q;
  logic                                  valid_q;
  logic                                  push;
  logic                                  pop;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry;

  assign fifo_full_out  = (count_q == COUNT_WIDTH_IN_BITS'(NUM_ENTRY));
  assign fifo_empty_out = (count_q == '0);
  assign count_out      = count_q;
  assign issue_ack_out  = !fifo_full_out;

  assign push = request_valid_in & issue_ack_out;
  assign pop  = valid_q & issue_ack_in;

  // Look one entry ahead on a pop so the next head is already registered
  // next cycle; pointer width makes the increment wrap modulo NUM_ENTRY.
  assign read_addr = pop ? (head_q + PTR_WIDTH_IN_BITS'(1)) : head_q;

  // Pointer, occupancy and presented-valid state. The valid term ignores this
  // cycle's push so a read never targets a slot being written in the same cycle.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_WIDTH_IN_BITS'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_WIDTH_IN_BITS'(1);
      end
      count_q <= count_q + COUNT_WIDTH_IN_BITS'(push) - COUNT_WIDTH_IN_BITS'(pop);
      valid_q <= (count_q - COUNT_WIDTH_IN_BITS'(pop)) != '0;
    end
  end

  dual_port_lutram #(
    .SINGLE_ENTRY_WIDTH_IN_BITS (SINGLE_ENTRY_WIDTH_IN_BITS),
    .NUM_SET                    (NUM_ENTRY),
    .SET_PTR_WIDTH_IN_BITS      (PTR_WIDTH_IN_BITS),
    .CONFIG_MODE                ("ReadFirst"),
    .WITH_VALID_REG_ARRAY       ("No")
  ) u_storage (
    .reset_in          (reset_in),
    .clk_in            (clk_in),
    .read_en_in        (1'b1),
    .read_set_addr_in  (read_addr),
    .read_entry_out    (read_entry),
    .access_en_in      (push),
    .write_en_in       ({NUM_BYTES{1'b1}}),
    .write_set_addr_in (tail_q),
    .write_entry_in    (request_in)
  );

  assign request_valid_out = valid_q;
  assign request_out       = valid_q ? read_entry : '0;

endmodule

// File: tb/tb_lutram_fifo.sv
// Scoreboard bench for lutram_fifo (depth 4, 64-bit entries).
module tb_lutram_fifo;

  localparam int unsigned W     = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          request_valid_in = 1'b0;
  logic [W-1:0]  request_in = '0;
  logic          issue_ack_out;
  logic          request_valid_out;
  logic [W-1:0]  request_out;
  logic          issue_ack_in = 1'b0;
  logic          fifo_full_out;
  logic          fifo_empty_out;
  logic [CW-1:0] count_out;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [W-1:0]  sb [$];
  bit            mon_en = 1'b0;

  lutram_fifo #(
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .NUM_ENTRY                  (DEPTH)
  ) dut (
    .reset_in          (reset_in),
    .clk_in            (clk_in),
    .request_valid_in  (request_valid_in),
    .request_in        (request_in),
    .issue_ack_out     (issue_ack_out),
    .request_valid_out (request_valid_out),
    .request_out       (request_out),
    .issue_ack_in      (issue_ack_in),
    .fifo_full_out     (fifo_full_out),
    .fifo_empty_out    (fifo_empty_out),
    .count_out         (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Offer one entry for one cycle; the expected acceptance is hand-supplied.
  task automatic drive_push(input logic [W-1:0] data, input logic accept);
    request_valid_in = 1'b1;
    request_in       = data;
    @(negedge clk_in);
    check("push_accept", W'(issue_ack_out), W'(accept));
    if (accept) sb.push_back(data);
    tick();
  endtask

  task automatic drain(input int unsigned max_cycles);
    issue_ack_in = 1'b1;
    for (int unsigned i = 0; i < max_cycles && !fifo_empty_out; i++) tick();
    check("drain_empty", W'(fifo_empty_out), 64'd1);
    check("drain_sb_left", W'(sb.size()), 64'd0);
    issue_ack_in = 1'b0;
  endtask

  // Monitor: whenever a head is presented it must match the scoreboard front.
  always @(negedge clk_in) begin
    if (mon_en && !reset_in) begin
      if (request_valid_out) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got head %h presented, expected no entry", request_out);
        end else begin
          check("head_data", request_out, sb[0]);
          if (issue_ack_in) void'(sb.pop_front());
        end
      end else begin
        check("idle_data_zero", request_out, 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Power-on reset, released mid-cycle.
    #2;
    check("rst_valid", W'(request_valid_out), 64'd0);
    check("rst_count", W'(count_out), 64'd0);
    check("rst_empty", W'(fifo_empty_out), 64'd1);
    check("rst_full", W'(fifo_full_out), 64'd0);
    #10 reset_in = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_in);
    check("rst_ack_out", W'(issue_ack_out), 64'd1);
    tick();

    // Single entry: latency 2, empty one cycle after the pop.
    drive_push(64'hA5, 1'b1);
    request_valid_in = 1'b0;
    @(negedge clk_in);
    check("lat_c1_valid", W'(request_valid_out), 64'd0);
    tick();
    issue_ack_in = 1'b1;
    @(negedge clk_in);
    check("lat_c2_valid", W'(request_valid_out), 64'd1);
    check("lat_c2_data", request_out, 64'hA5);
    tick();
    issue_ack_in = 1'b0;
    @(negedge clk_in);
    check("single_empty", W'(fifo_empty_out), 64'd1);
    check("single_valid", W'(request_valid_out), 64'd0);
    tick();

    // Fill to full, refuse a fifth push, then drain back-to-back.
    for (int unsigned k = 1; k <= 4; k++) drive_push(W'(k), 1'b1);
    request_in = 64'd5;
    @(negedge clk_in);
    check("full_flag", W'(fifo_full_out), 64'd1);
    check("full_ack_out", W'(issue_ack_out), 64'd0);
    tick();
    request_valid_in = 1'b0;
    @(negedge clk_in);
    check("full_count", W'(count_out), 64'd4);
    tick();
    issue_ack_in = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("pop_no_bubble", W'(request_valid_out), 64'd1);
      tick();
    end
    issue_ack_in = 1'b0;
    @(negedge clk_in);
    check("fill_drained", W'(fifo_empty_out), 64'd1);
    tick();

    // Streaming: push and pop every cycle.
    issue_ack_in = 1'b1;
    for (int unsigned k = 0; k < 20; k++) begin
      request_valid_in = 1'b1;
      request_in       = 64'h10 + W'(k);
      @(negedge clk_in);
      check("stream_accept", W'(issue_ack_out), 64'd1);
      sb.push_back(64'h10 + W'(k));
      if (k >= 2) begin
        check("stream_valid", W'(request_valid_out), 64'd1);
        check("stream_count", W'(count_out), 64'd2);
      end
      tick();
    end
    request_valid_in = 1'b0;
    drain(8);

    // Consumer stall with three entries queued.
    for (int unsigned k = 1; k <= 3; k++) drive_push(64'h30 + W'(k), 1'b1);
    request_valid_in = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("stall_valid", W'(request_valid_out), 64'd1);
      check("stall_data", request_out, 64'h31);
      tick();
    end
    drain(8);

    // Reset mid-operation.
    for (int unsigned k = 1; k <= 3; k++) drive_push(64'h40 + W'(k), 1'b1);
    request_valid_in = 1'b0;
    tick();
    #2 reset_in = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_valid", W'(request_valid_out), 64'd0);
    check("mid_rst_count", W'(count_out), 64'd0);
    check("mid_rst_empty", W'(fifo_empty_out), 64'd1);
    check("mid_rst_data", request_out, 64'd0);
    @(posedge clk_in);
    #3 reset_in = 1'b0;
    @(negedge clk_in);
    check("mid_rst_ack_out", W'(issue_ack_out), 64'd1);
    tick();
    drive_push(64'h77, 1'b1);
    request_valid_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_c1_valid", W'(request_valid_out), 64'd0);
    tick();
    issue_ack_in = 1'b1;
    @(negedge clk_in);
    check("post_rst_c2_valid", W'(request_valid_out), 64'd1);
    check("post_rst_c2_data", request_out, 64'h77);
    tick();
    issue_ack_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_alone", W'(request_valid_out), 64'd0);
    check("post_rst_empty", W'(fifo_empty_out), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
